led_status_arbiter: RTL
=======================

// Module: led_status_arbiter
// PURPOSE
//  Shares the single on-board RGB LED between NREQ status requesters. Picks the
//  highest-priority active requester and enforces a minimum display time.
//  Cross-fades between colours and renders per-requester modes: solid, blink or breathe.
//  Its bright_r/g/b/enable outputs feed rgb_drv directly, which applies the
//  exponential map and current-limited drive.
// PARAMETERS
//  NREQ        4      number of requesters; index NREQ-1 is highest priority
//  TICK_DIV    12000  clk cycles per animation tick (1 ms at 12 MHz); >=2
//  MIN_HOLD    50     ticks a grant is held before a higher requester may preempt
//  FADE_STEP   8      max per-channel change per tick during a fade (1..255)
//  BLINK_HALF  250    ticks per blink half-period
// PORTS
//  clk       in   1        system clock
//  reset_n   in   1        asynchronous active-low reset
//  req       in   NREQ     request lines, level-sensitive
//  color     in   24*NREQ  {r,g,b} per requester; requester i = color[24*i+:24]
//  mode      in   2*NREQ   per requester: 00 solid, 01 blink, 10 breathe, 11 = solid
//  bright_r  out  8        red level to rgb_drv
//  bright_g  out  8        green level to rgb_drv
//  bright_b  out  8        blue level to rgb_drv
//  enable    out  1        LED driver enable (rgb_drv.enable)
//  grant     out  NREQ     one-hot current owner; all-zero when none
//  busy      out  1        high while a fade is in progress
// BEHAVIOUR
//  Reset (async, immediate): state IDLE. bright_* = 0, enable = 0, grant = 0, busy = 0.
//   All counters are cleared. A reset mid-fade or mid-show drops the outputs without waiting for clk.
//  Tick: a prescaler counts 0..TICK_DIV-1 and wraps. tick pulses for 1 clk at TICK_DIV-1.
//  winner: the highest index with req = 1, evaluated every clk.
//  hold_cnt: cleared on every grant change; +1 per tick; saturates at MIN_HOLD.
//  States: IDLE, FADE, SHOW. Every output is registered.
//   IDLE: outputs 0. When any req is high -> grant = winner on the next edge,
//    latch target = color[winner] and mode, go to FADE. Levels start from 0.
//   FADE: busy = 1. On each tick, every channel moves toward the target by
//    min(FADE_STEP, |target - level|). No overshoot; unsigned 8-bit values, no wrap.
//    The first clk after all three channels equal the target:
//     - grant != 0: go to SHOW and clear the animation phase.
//     - grant == 0 (fade-out, target 0): go to IDLE; enable falls on the same edge.
//   SHOW: the output depends on the latched mode.
//    - solid: output = target.
//    - blink: a phase bit toggles every BLINK_HALF ticks, starting "on";
//      output = target when on, else 0. No fading inside the blink.
//    - breathe: a 9-bit triangle lvl steps 1 per tick (0..255 then 255..0, wraps).
//      output = (target * lvl) >> 8 per channel (16-bit product, top 8 bits).
//    - Holder colour or mode changes while in SHOW -> re-latch the target and
//      go to FADE, starting from the current displayed level.
//  Re-arbitration (FADE or SHOW, grant != 0):
//   - Granted req falls: release at once, regardless of hold_cnt.
//     Another req high -> grant = new winner, FADE to its colour.
//     No req high -> grant = 0, FADE to 0 (fade-out).
//   - winner != holder while the holder's req is still high: switch only once
//     hold_cnt == MIN_HOLD. Then grant = winner and FADE to its colour.
//   - During fade-out, any req arbitrates immediately (no hold applies).
//   - Every fade starts from the instantaneous displayed levels, including
//     mid-blink or mid-breathe values.
//  enable = 1 in FADE and SHOW, 0 in IDLE. grant is always one-hot or zero.
//  Latency: req rises in IDLE -> grant/enable after 1 clk edge; the first level
//   change occurs on the next tick.
//  Simultaneous events on one edge: holder release plus a new req -> the new winner
//   gets the grant on that edge. reset_n overrides everything.
// TESTING  (TICK_DIV=4, MIN_HOLD=3, FADE_STEP=8, BLINK_HALF=2)
//  1 req[0]=1, solid, 0x102030 -> grant=0001 after 1 clk. Per tick r 8,16; g to 0x20
//    in 4 ticks; b to 0x30 in 6 ticks. busy falls 1 clk after b=0x30; outputs hold.
//  2 Holder req0, req2 rises at hold_cnt=1 -> grant stays 0001 until hold_cnt=3,
//    then 0100. Channels fade in 8-steps from 0x102030 toward color[2].
//  3 Holder drops req0, no other req -> grant=0000 on the next edge, enable stays 1,
//    fade to 0. enable=0 one clk after all channels reach 0.
//  4 Blink mode, 0xFF0000, after fade-in -> r = FF,FF,00,00,FF... per tick; g=b=0.
//  5 Breathe mode, 0x800000 -> r = (0x80*lvl)>>8: 0 at lvl 0, 0x7F at lvl 255,
//    symmetric on the way down.
//  6 reset_n low mid-fade, between clk edges -> all outputs 0 immediately;
//    req held across the release -> grant after 1 clk, fade restarts from 0.

Source files
------------

// File: rtl/led_status_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : led_status_arbiter
// Description : Shares one RGB LED between NREQ status requesters. Highest
//               index wins, with a minimum hold before preemption. Colour
//               changes cross-fade; the shown colour is rendered solid,
//               blinking or breathing.
// Revision    : 1.0 - initial release
// ============================================================================
module led_status_arbiter #(
  parameter int NREQ       = 4,
  parameter int TICK_DIV   = 12000,
  parameter int MIN_HOLD   = 50,
  parameter int FADE_STEP  = 8,
  parameter int BLINK_HALF = 250
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [24*NREQ-1:0]   color,
  input  logic [2*NREQ-1:0]    mode,
  output logic [7:0]           bright_r,
  output logic [7:0]           bright_g,
  output logic [7:0]           bright_b,
  output logic                 enable,
  output logic [NREQ-1:0]      grant,
  output logic                 busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [7:0]    STEP8      = 8'(FADE_STEP);
  localparam logic [1:0]    M_BLINK    = 2'b01;
  localparam logic [1:0]    M_BREATHE  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FADE = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pre;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [BW-1:0]   blink_cnt, blink_cnt_n;
  logic            blink_on, blink_on_n;
  logic [8:0]      breath, breath_n;
  logic [IW-1:0]   gidx, gidx_n;
  logic [NREQ-1:0] grant_n;
  logic [23:0]     tgt, tgt_n;
  logic [1:0]      tmode, tmode_n;
  logic [23:0]     lvl, lvl_n;

  logic            tick;
  logic [IW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic [23:0]     win_col, hold_col;
  logic [1:0]      win_mode, hold_mode;
  logic            any_req, holder_live, take, drop, at_tgt;
  logic [7:0]      bl;

  // Move one channel toward its target by at most FADE_STEP, never past it.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] dst);
    logic [7:0] diff;
    if (cur < dst) begin
      diff = dst - cur;
      step_toward = (diff > STEP8) ? cur + STEP8 : dst;
    end else begin
      diff = cur - dst;
      step_toward = (diff > STEP8) ? cur - STEP8 : dst;
    end
  endfunction

  // Top 8 bits of the 16-bit product of colour and breathe level.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] l);
    logic [15:0] p;
    p = {8'd0, c} * {8'd0, l};
    scale = p[15:8];
  endfunction

  assign tick     = (pre == PRE_LAST);
  assign bright_r = lvl[23:16];
  assign bright_g = lvl[15:8];
  assign bright_b = lvl[7:0];

  // Winner (highest active index) and the current holder's colour/mode.
  always_comb begin
    win       = '0;
    win_col   = '0;
    win_mode  = '0;
    hold_col  = '0;
    hold_mode = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) win = IW'(i);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        win_col  = color[24*i +: 24];
        win_mode = mode[2*i +: 2];
      end
      if (gidx == IW'(i)) begin
        hold_col  = color[24*i +: 24];
        hold_mode = mode[2*i +: 2];
      end
    end
    win_oh      = NREQ'(1) << win;
    any_req     = |req;
    holder_live = |(req & grant);
    at_tgt      = (lvl == tgt);
    bl          = breath[8] ? ~breath[7:0] : breath[7:0];
  end

  // Next-state logic: arbitration first, then fade / render per state.
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    gidx_n      = gidx;
    tgt_n       = tgt;
    tmode_n     = tmode;
    lvl_n       = lvl;
    blink_cnt_n = blink_cnt;
    blink_on_n  = blink_on;
    breath_n    = breath;
    hold_n      = hold_cnt;

    // Fade-out (grant==0) and IDLE take any requester at once; a released
    // holder is replaced at once; a live holder only after the hold expires.
    take = any_req && ((grant == '0) || !holder_live ||
                       ((win != gidx) && (hold_cnt == HOLD_MAX)));
    drop = (grant != '0) && !holder_live && !any_req;

    if (take) begin
      grant_n = win_oh;
      gidx_n  = win;
      tgt_n   = win_col;
      tmode_n = win_mode;
      state_n = S_FADE;
    end else if (drop) begin
      grant_n = '0;
      tgt_n   = '0;
      state_n = S_FADE;
    end else begin
      case (state)
        S_IDLE: lvl_n = '0;
        S_FADE: begin
          if (at_tgt) begin
            state_n     = (grant != '0) ? S_SHOW : S_IDLE;
            blink_cnt_n = '0;
            blink_on_n  = 1'b1;
            breath_n    = '0;
          end else if (tick) begin
            lvl_n = {step_toward(lvl[23:16], tgt[23:16]),
                     step_toward(lvl[15:8],  tgt[15:8]),
                     step_toward(lvl[7:0],   tgt[7:0])};
          end
        end
        S_SHOW: begin
          if ((hold_col != tgt) || (hold_mode != tmode)) begin
            tgt_n   = hold_col;
            tmode_n = hold_mode;
            state_n = S_FADE;
          end else if (tmode == M_BLINK) begin
            lvl_n = blink_on ? tgt : 24'd0;
            if (tick) begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt_n = '0;
                blink_on_n  = ~blink_on;
              end else begin
                blink_cnt_n = blink_cnt + 1'b1;
              end
            end
          end else if (tmode == M_BREATHE) begin
            lvl_n = {scale(tgt[23:16], bl), scale(tgt[15:8], bl), scale(tgt[7:0], bl)};
            if (tick) breath_n = breath + 1'b1;
          end else begin
            lvl_n = tgt;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (grant_n != grant) hold_n = '0;
    else if (tick && (hold_cnt != HOLD_MAX)) hold_n = hold_cnt + 1'b1;
  end

  // State, counters and all outputs are registered; reset drops them at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pre       <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      breath    <= '0;
      gidx      <= '0;
      grant     <= '0;
      tgt       <= '0;
      tmode     <= '0;
      lvl       <= '0;
      enable    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      pre       <= tick ? '0 : pre + 1'b1;
      hold_cnt  <= hold_n;
      blink_cnt <= blink_cnt_n;
      blink_on  <= blink_on_n;
      breath    <= breath_n;
      gidx      <= gidx_n;
      grant     <= grant_n;
      tgt       <= tgt_n;
      tmode     <= tmode_n;
      lvl       <= lvl_n;
      enable    <= (state_n != S_IDLE);
      busy      <= (state_n == S_FADE);
    end
  end

endmodule
`default_nettype wire
